// File: rtl/phy_rx_unstriper.sv
// Two-lane byte unstriper: per-lane deskew FIFOs feed a two-phase pairing FSM
// that rebuilds 32-bit words (lane0 carries bytes 3/1, lane1 carries bytes 2/0).
module phy_rx_unstriper #(
    parameter int DEPTH = 4
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [7:0]  data_in_0,
    input  logic        valid_in_0,
    input  logic [7:0]  data_in_1,
    input  logic        valid_in_1,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        overflow_err,
    output logic        o_dbg_phase
);

    // Interface handshake: valid-only, no backpressure. A lane byte is taken
    // at every posedge where its valid_in is high; valid_out is a one-cycle
    // strobe for the word on data_out and the consumer must accept it.

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } phase_t;

    phase_t          r_phase;
    phase_t          w_phase_nxt;

    logic [7:0]      r_mem0 [DEPTH];
    logic [7:0]      r_mem1 [DEPTH];
    logic [AW-1:0]   r_wptr0;
    logic [AW-1:0]   r_rptr0;
    logic [AW-1:0]   r_wptr1;
    logic [AW-1:0]   r_rptr1;
    logic [AW:0]     r_cnt0;
    logic [AW:0]     r_cnt1;

    logic [15:0]     r_hold;
    logic [31:0]     r_data_out;
    logic            r_valid_out;
    logic            r_ovf_err;

    logic            w_empty0;
    logic            w_empty1;
    logic            w_full0;
    logic            w_full1;
    logic            w_pop;
    logic            w_ovf;
    logic            w_push0;
    logic            w_push1;
    logic [7:0]      w_rd0;
    logic [7:0]      w_rd1;

    // Flags come only from registered counts, so a byte pushed this edge is
    // never popped in the same edge.
    assign w_empty0 = (r_cnt0 == '0);
    assign w_empty1 = (r_cnt1 == '0);
    assign w_full0  = (r_cnt0 == FULL_CNT);
    assign w_full1  = (r_cnt1 == FULL_CNT);
    assign w_pop    = !w_empty0 && !w_empty1;

    // A pop frees a slot in a full FIFO, so overflow needs a push with no pop.
    assign w_ovf    = ((valid_in_0 && w_full0) || (valid_in_1 && w_full1)) && !w_pop;
    assign w_push0  = valid_in_0 && !w_ovf;
    assign w_push1  = valid_in_1 && !w_ovf;

    assign w_rd0    = r_mem0[r_rptr0];
    assign w_rd1    = r_mem1[r_rptr1];

    always_ff @(posedge clk_4f) begin
        if (w_push0) begin
            r_mem0[r_wptr0] <= data_in_0;
        end
        if (w_push1) begin
            r_mem1[r_wptr1] <= data_in_1;
        end
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            r_wptr0 <= '0;
            r_rptr0 <= '0;
            r_cnt0  <= '0;
            r_wptr1 <= '0;
            r_rptr1 <= '0;
            r_cnt1  <= '0;
        end else if (w_ovf) begin
            r_wptr0 <= '0;
            r_rptr0 <= '0;
            r_cnt0  <= '0;
            r_wptr1 <= '0;
            r_rptr1 <= '0;
            r_cnt1  <= '0;
        end else begin
            if (w_push0) begin
                r_wptr0 <= r_wptr0 + AW'(1);
            end
            if (w_push1) begin
                r_wptr1 <= r_wptr1 + AW'(1);
            end
            if (w_pop) begin
                r_rptr0 <= r_rptr0 + AW'(1);
                r_rptr1 <= r_rptr1 + AW'(1);
            end
            r_cnt0 <= r_cnt0 + (AW+1)'(w_push0) - (AW+1)'(w_pop);
            r_cnt1 <= r_cnt1 + (AW+1)'(w_push1) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            r_phase <= PH_HI;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        if (w_ovf) begin
            w_phase_nxt = PH_HI;
        end else if (w_pop) begin
            case (r_phase)
                PH_HI:   w_phase_nxt = PH_LO;
                PH_LO:   w_phase_nxt = PH_HI;
                default: w_phase_nxt = PH_HI;
            endcase
        end
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            r_hold      <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_ovf_err   <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            if (w_ovf) begin
                r_hold    <= '0;
                r_ovf_err <= 1'b1;
            end else if (w_pop) begin
                if (r_phase == PH_HI) begin
                    r_hold <= {w_rd0, w_rd1};
                end else begin
                    r_data_out  <= {r_hold, w_rd0, w_rd1};
                    r_valid_out <= 1'b1;
                end
            end
        end
    end

    assign data_out     = r_data_out;
    assign valid_out    = r_valid_out;
    assign overflow_err = r_ovf_err;
    assign o_dbg_phase  = r_phase;

endmodule
